// File: rtl/sensor_timing_gen.sv
// Programmable HD/VD sensor timing generator with shadowed geometry and continuous/oneshot run modes.
// Optional completed-frame counter is built only when TG_FRAME_COUNT_EN is defined.
module sensor_timing_gen #(
    parameter int HW          = 16,
    parameter int VW          = 13,
    parameter int DEF_H_TOTAL = 64,
    parameter int DEF_H_BLANK = 6,
    parameter int DEF_V_TOTAL = 32,
    parameter int DEF_V_BLANK = 3,
    parameter int FCW         = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           oneshot,
    input  logic           trig,
    input  logic [HW-1:0]  cfg_h_total,
    input  logic [HW-1:0]  cfg_h_blank,
    input  logic [VW-1:0]  cfg_v_total,
    input  logic [VW-1:0]  cfg_v_blank,
    input  logic           cfg_load,
    output logic           cfg_err,
    output logic           hd,
    output logic           vd,
    output logic           de,
    output logic           sof,
    output logic           eol,
    output logic [HW-1:0]  h_cnt,
    output logic [VW-1:0]  v_cnt,
    output logic           busy,
    output logic [FCW-1:0] frame_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [HW-1:0] ah_t, ah_b, ph_t, ph_b;
    logic [VW-1:0] av_t, av_b, pv_t, pv_b;
    logic          cfg_ok, run, start, h_last, v_last, frame_end, transfer;

    assign cfg_ok    = cfg_load
                     && (cfg_h_total >= HW'(2)) && (cfg_h_blank < cfg_h_total)
                     && (cfg_v_total >= VW'(1)) && (cfg_v_blank < cfg_v_total);
    assign run       = (state == RUN);
    assign start     = oneshot ? trig : en;
    assign h_last    = (h_cnt == ah_t - HW'(1));
    assign v_last    = (v_cnt == av_t - VW'(1));
    assign frame_end = run && h_last && v_last;
    // Active geometry may only change while no frame is in flight.
    assign transfer  = !run || frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            ah_t    <= HW'(DEF_H_TOTAL);
            ah_b    <= HW'(DEF_H_BLANK);
            av_t    <= VW'(DEF_V_TOTAL);
            av_b    <= VW'(DEF_V_BLANK);
            ph_t    <= HW'(DEF_H_TOTAL);
            ph_b    <= HW'(DEF_H_BLANK);
            pv_t    <= VW'(DEF_V_TOTAL);
            pv_b    <= VW'(DEF_V_BLANK);
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_ok) begin
                ph_t <= cfg_h_total;
                ph_b <= cfg_h_blank;
                pv_t <= cfg_v_total;
                pv_b <= cfg_v_blank;
            end
            // A load coinciding with the transfer point bypasses the pending copy.
            if (transfer) begin
                ah_t <= cfg_ok ? cfg_h_total : ph_t;
                ah_b <= cfg_ok ? cfg_h_blank : ph_b;
                av_t <= cfg_ok ? cfg_v_total : pv_t;
                av_b <= cfg_ok ? cfg_v_blank : pv_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (h_last) begin
                        h_cnt <= '0;
                        if (v_last) begin
                            v_cnt <= '0;
                            if (oneshot || !en) state <= IDLE;
                        end else begin
                            v_cnt <= v_cnt + VW'(1);
                        end
                    end else begin
                        h_cnt <= h_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = run;
    assign hd   = run && (h_cnt >= ah_b);
    assign vd   = run && (v_cnt >= av_b);
    assign de   = hd && vd;
    assign sof  = run && (h_cnt == '0) && (v_cnt == '0);
    assign eol  = run && h_last;

`ifdef TG_FRAME_COUNT_EN
    logic [FCW-1:0] fcnt;

    always_ff @(posedge clk) begin
        if (rst)
            fcnt <= '0;
        else if (frame_end)
            fcnt <= fcnt + FCW'(1);
    end

    assign frame_cnt = fcnt;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_sensor_timing_gen.sv
// Directed bench for sensor_timing_gen: a per-cycle frame-position model feeds a scoreboard queue,
// plus frame-level counts (length, de/hd/vd/eol totals) compared against hand-derived numbers.
module tb_sensor_timing_gen;

    logic        clk, rst, en, oneshot, trig, cfg_load;
    logic [15:0] cfg_h_total, cfg_h_blank;
    logic [12:0] cfg_v_total, cfg_v_blank;
    logic        cfg_err, hd, vd, de, sof, eol, busy;
    logic [15:0] h_cnt;
    logic [12:0] v_cnt;
    logic [15:0] frame_cnt;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] sb_q[$];

    // Reference model state: frame position as a linear index.
    int m_run = 0, m_pos = 0, m_err = 0, m_fc = 0;
    int a_ht = 64, a_hb = 6, a_vt = 32, a_vb = 3;
    int p_ht = 64, p_hb = 6, p_vt = 32, p_vb = 3;

    sensor_timing_gen dut (
        .clk(clk), .rst(rst), .en(en), .oneshot(oneshot), .trig(trig),
        .cfg_h_total(cfg_h_total), .cfg_h_blank(cfg_h_blank),
        .cfg_v_total(cfg_v_total), .cfg_v_blank(cfg_v_blank),
        .cfg_load(cfg_load), .cfg_err(cfg_err),
        .hd(hd), .vd(vd), .de(de), .sof(sof), .eol(eol),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .busy(busy), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int hv, vv, last;
        hv = (cfg_load === 1'b1) && (int'(cfg_h_total) >= 2) && (int'(cfg_h_blank) < int'(cfg_h_total))
             && (int'(cfg_v_total) >= 1) && (int'(cfg_v_blank) < int'(cfg_v_total));
        if (rst) begin
            m_run = 0; m_pos = 0; m_err = 0; m_fc = 0;
            a_ht = 64; a_hb = 6; a_vt = 32; a_vb = 3;
            p_ht = 64; p_hb = 6; p_vt = 32; p_vb = 3;
        end else begin
            m_err = (cfg_load === 1'b1) && !hv;
            last  = a_ht * a_vt - 1;
            vv    = (m_run == 0) || (m_pos == last);
            if (m_run == 0) begin
                if ((!oneshot && en) || (oneshot && trig)) m_run = 1;
                m_pos = 0;
            end else if (m_pos == last) begin
                m_pos = 0;
                m_fc  = (m_fc + 1) % 65536;
                if (oneshot || !en) m_run = 0;
            end else begin
                m_pos++;
            end
            if (vv) begin
                if (hv) begin
                    a_ht = int'(cfg_h_total); a_hb = int'(cfg_h_blank);
                    a_vt = int'(cfg_v_total); a_vb = int'(cfg_v_blank);
                end else begin
                    a_ht = p_ht; a_hb = p_hb; a_vt = p_vt; a_vb = p_vb;
                end
            end
            if (hv) begin
                p_ht = int'(cfg_h_total); p_hb = int'(cfg_h_blank);
                p_vt = int'(cfg_v_total); p_vb = int'(cfg_v_blank);
            end
        end
    endtask

    function automatic logic [63:0] model_vec();
        int h, v;
        logic e_hd, e_vd, e_sof, e_eol;
        logic [15:0] e_fc;
        h = (m_run != 0) ? (m_pos % a_ht) : 0;
        v = (m_run != 0) ? (m_pos / a_ht) : 0;
        e_hd  = (m_run != 0) && (h >= a_hb);
        e_vd  = (m_run != 0) && (v >= a_vb);
        e_sof = (m_run != 0) && (m_pos == 0);
        e_eol = (m_run != 0) && (h == a_ht - 1);
`ifdef TG_FRAME_COUNT_EN
        e_fc = 16'(m_fc);
`else
        e_fc = 16'd0;
`endif
        return {12'd0, (m_run != 0), e_hd, e_vd, e_hd & e_vd, e_sof, e_eol, (m_err != 0),
                16'(h), 13'(v), e_fc};
    endfunction

    function automatic logic [63:0] obs_vec();
        return {12'd0, busy, hd, vd, de, sof, eol, cfg_err, h_cnt, v_cnt, frame_cnt};
    endfunction

    task automatic tick();
        logic [63:0] exp;
        model_step();
        sb_q.push_back(model_vec());
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check("cycle", obs_vec(), exp);
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(int'(h_cnt) == h && int'(v_cnt) == v) && n < 5000) begin
            tick();
            n++;
        end
        check("reach_h", 64'(h_cnt), 64'(h));
        check("reach_v", 64'(v_cnt), 64'(v));
    endtask

    task automatic wait_sof();
        int n = 0;
        while (sof !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check("reach_sof", 64'(sof), 64'd1);
    endtask

    // Starts on a sof sample; counts cycles until the next sof or until busy drops.
    task automatic measure(output int len, output int de_n, output int hd_n,
                           output int vd_n, output int eol_n);
        len = 0; de_n = 0; hd_n = 0; vd_n = 0; eol_n = 0;
        do begin
            len++;
            de_n  += int'(de);
            hd_n  += int'(hd);
            vd_n  += int'(vd);
            eol_n += int'(eol);
            tick();
        end while (sof !== 1'b1 && busy === 1'b1 && len < 5000);
    endtask

    initial begin
        int len, de_n, hd_n, vd_n, eol_n, n, busy_n, sof_n, lh, lv, exp_fc;

        rst = 1'b1; en = 1'b0; oneshot = 1'b0; trig = 1'b0; cfg_load = 1'b0;
        cfg_h_total = 16'd0; cfg_h_blank = 16'd0; cfg_v_total = 13'd0; cfg_v_blank = 13'd0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hcnt", 64'(h_cnt), 64'd0);

        // Defaults, continuous
        en = 1'b1;
        tick();
        check("start_sof", 64'(sof), 64'd1);
        measure(len, de_n, hd_n, vd_n, eol_n);
        check("def_len", 64'(len), 64'd2048);
        check("def_de", 64'(de_n), 64'd1682);
        check("def_hd", 64'(hd_n), 64'd1856);
        check("def_vd", 64'(vd_n), 64'd1856);
        check("def_eol", 64'(eol_n), 64'd32);
        measure(len, de_n, hd_n, vd_n, eol_n);
        check("def_len2", 64'(len), 64'd2048);

        // Disable mid-frame
        wait_pos(0, 10);
        en = 1'b0;
        n = 0; lh = 0; lv = 0;
        while (busy === 1'b1 && n < 5000) begin
            lh = int'(h_cnt); lv = int'(v_cnt);
            tick();
            n++;
        end
        check("dis_last_h", 64'(lh), 64'd63);
        check("dis_last_v", 64'(lv), 64'd31);
        check("dis_idle_busy", 64'(busy), 64'd0);
        check("dis_idle_hd", 64'(hd), 64'd0);

        // Oneshot with an ignored second trigger
        oneshot = 1'b1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("os_sof", 64'(sof), 64'd1);
        n = 0; busy_n = 0; sof_n = 0;
        while (busy === 1'b1 && n < 5000) begin
            busy_n++;
            sof_n += int'(sof);
            trig = (n == 100);
            tick();
            n++;
        end
        trig = 1'b0;
        check("os_len", 64'(busy_n), 64'd2048);
        check("os_sof_cnt", 64'(sof_n), 64'd1);
        tick(); tick(); tick();
        check("os_idle", 64'(busy), 64'd0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("os_restart", 64'(sof), 64'd1);

        // Shadowed load mid-frame, switching to continuous
        oneshot = 1'b0; en = 1'b1;
        cfg_h_total = 16'd100; cfg_h_blank = 16'd10; cfg_v_total = 13'd20; cfg_v_blank = 13'd2;
        len = 0;
        do begin
            cfg_load = (h_cnt == 16'd0 && v_cnt == 13'd5);
            tick();
            len++;
        end while (sof !== 1'b1 && len < 5000);
        cfg_load = 1'b0;
        check("sh_cur_len", 64'(len), 64'd2048);
        measure(len, de_n, hd_n, vd_n, eol_n);
        check("sh_new_len", 64'(len), 64'd2000);
        check("sh_new_eol", 64'(eol_n), 64'd20);
        check("sh_new_de", 64'(de_n), 64'd1620);

        // Invalid load rejected
        cfg_h_total = 16'd8; cfg_h_blank = 16'd8;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("err_pulse", 64'(cfg_err), 64'd1);
        tick();
        check("err_clear", 64'(cfg_err), 64'd0);
        wait_sof();
        measure(len, de_n, hd_n, vd_n, eol_n);
        check("err_geom_kept", 64'(len), 64'd2000);

        // Reset mid-frame after three default frames
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rs_start", 64'(sof), 64'd1);
        for (int f = 0; f < 3; f++) measure(len, de_n, hd_n, vd_n, eol_n);
        wait_pos(30, 7);
`ifdef TG_FRAME_COUNT_EN
        exp_fc = 3;
`else
        exp_fc = 0;
`endif
        check("rs_fc_before", 64'(frame_cnt), 64'(exp_fc));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_hcnt", 64'(h_cnt), 64'd0);
        check("rs_vcnt", 64'(v_cnt), 64'd0);
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_fc", 64'(frame_cnt), 64'd0);
        tick();
        check("rs_sof", 64'(sof), 64'd1);
        measure(len, de_n, hd_n, vd_n, eol_n);
        check("rs_def_len", 64'(len), 64'd2048);
        check("rs_def_de", 64'(de_n), 64'd1682);

        en = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
